snake_body: RTL and testbench

- Consumes the debounced one-hot `direction` from the direction generator and advances the snake one grid cell per step tick.
- Holds a shift register of up to MAX_LEN segment coordinates and grows the snake when it eats food.
- Detects wall and self collisions and latches game over.
- Provides head position, length and a per-cell occupancy query for the VGA renderer and the food generator.

---
 rtl/snake_body.sv | 91 +++++++++
 tb/tb_snake_body.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/snake_body.sv
// snake_body: step-timed snake segment shift register with growth, wall/self collision and occupancy query
module snake_body #(
  parameter int GRID_W   = 40,
  parameter int GRID_H   = 30,
  parameter int X_W      = 6,
  parameter int Y_W      = 5,
  parameter int MAX_LEN  = 16,
  parameter int L_W      = 5,
  parameter int INIT_LEN = 3,
  parameter int INIT_X   = 20,
  parameter int INIT_Y   = 5,
  parameter int STEP_DIV = 5000000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [3:0]     direction,
  input  logic [X_W-1:0] food_x,
  input  logic [Y_W-1:0] food_y,
  input  logic           food_valid,
  input  logic [X_W-1:0] query_x,
  input  logic [Y_W-1:0] query_y,
  output logic [X_W-1:0] head_x,
  output logic [Y_W-1:0] head_y,
  output logic [L_W-1:0] length,
  output logic           step,
  output logic           ate,
  output logic           game_over,
  output logic           query_hit
);
  localparam int CW = $clog2(STEP_DIV);
  logic [CW-1:0]  cnt;
  logic [X_W-1:0] seg_x [MAX_LEN];
  logic [Y_W-1:0] seg_y [MAX_LEN];
  logic [3:0]     heading, new_hd;
  logic [X_W:0]   nx;
  logic [Y_W:0]   ny;
  logic [L_W-1:0] lim;
  logic           tick, eat, wall, self_hit;
  assign tick   = en && !game_over && cnt == CW'(STEP_DIV - 1);
  assign new_hd = ($onehot(direction) && direction != {heading[2], heading[3], heading[0], heading[1]}) ? direction : heading;
  // one extra bit so a step off the low edge wraps to all-ones and fails the range check
  assign nx     = {1'b0, seg_x[0]} + (X_W+1)'(new_hd[0]) - (X_W+1)'(new_hd[1]);
  assign ny     = {1'b0, seg_y[0]} + (Y_W+1)'(new_hd[2]) - (Y_W+1)'(new_hd[3]);
  assign wall   = nx >= (X_W+1)'(GRID_W) || ny >= (Y_W+1)'(GRID_H);
  assign eat    = food_valid && nx == {1'b0, food_x} && ny == {1'b0, food_y};
  assign lim    = eat ? length : length - L_W'(1);
  assign head_x = seg_x[0];
  assign head_y = seg_y[0];
  always_comb begin
    self_hit  = 1'b0;
    query_hit = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      self_hit  = self_hit | (L_W'(i) < lim && {1'b0, seg_x[i]} == nx && {1'b0, seg_y[i]} == ny);
      query_hit = query_hit | (L_W'(i) < length && seg_x[i] == query_x && seg_y[i] == query_y);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      length    <= L_W'(INIT_LEN);
      step      <= 1'b0;
      ate       <= 1'b0;
      game_over <= 1'b0;
      heading   <= 4'b0100;
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x[i] <= X_W'(INIT_X);
        seg_y[i] <= Y_W'(INIT_Y - ((i < INIT_LEN) ? i : INIT_LEN - 1));
      end
    end else begin
      step <= 1'b0;
      ate  <= 1'b0;
      if (en && !game_over) cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) begin
        heading <= new_hd;
        if (wall || self_hit) game_over <= 1'b1;
        else begin
          seg_x[0] <= nx[X_W-1:0];
          seg_y[0] <= ny[Y_W-1:0];
          for (int i = 1; i < MAX_LEN; i++) begin
            seg_x[i] <= seg_x[i-1];
            seg_y[i] <= seg_y[i-1];
          end
          if (eat && length < L_W'(MAX_LEN)) length <= length + 1'b1;
          step <= 1'b1;
          ate  <= eat;
        end
      end
    end
  end
endmodule

// File: tb/tb_snake_body.sv
// tb_snake_body: table vectors, corner sequences and randomized run against a queue-based snake model
module tb_snake_body;
  localparam int SD = 4;
  logic       clk = 0, rst = 1, en = 0, food_valid = 0;
  logic [3:0] direction = 4'b0100;
  logic [5:0] food_x = 0, query_x = 0, head_x;
  logic [4:0] food_y = 0, query_y = 0, head_y, length;
  logic       step, ate, game_over, query_hit;
  snake_body #(.STEP_DIV(SD)) dut (
    .clk(clk), .rst(rst), .en(en), .direction(direction), .food_x(food_x), .food_y(food_y),
    .food_valid(food_valid), .query_x(query_x), .query_y(query_y), .head_x(head_x), .head_y(head_y),
    .length(length), .step(step), .ate(ate), .game_over(game_over), .query_hit(query_hit)
  );
  always #5 clk = ~clk;
  int errs = 0, checks = 0;
  int qx[$], qy[$];
  int m_cnt;
  logic [3:0] m_hd;
  bit m_step, m_ate, m_go, m_valid;
  typedef struct {
    int n; bit en; logic [3:0] dir; bit fv; int fx, fy, qx, qy;
    int hx, hy, len; bit st, at, go, qh;
  } vec_t;
  vec_t tbl[14];
  function automatic int dxf(logic [3:0] d);
    return d == 4'b0001 ? 1 : d == 4'b0010 ? -1 : 0;
  endfunction
  function automatic int dyf(logic [3:0] d);
    return d == 4'b0100 ? 1 : d == 4'b1000 ? -1 : 0;
  endfunction
  function automatic bit m_hit(int x, int y);
    foreach (qx[i]) if (qx[i] == x && qy[i] == y) return 1;
    return 0;
  endfunction
  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic m_move();
    int nx, ny;
    bit e, hit;
    if ($countones(direction) == 1 && !(dxf(direction) == -dxf(m_hd) && dyf(direction) == -dyf(m_hd)))
      m_hd = direction;
    nx = qx[0] + dxf(m_hd);
    ny = qy[0] + dyf(m_hd);
    e = food_valid && nx == int'(food_x) && ny == int'(food_y);
    hit = 0;
    for (int i = 0; i < qx.size(); i++)
      if ((i < qx.size() - 1 || e) && qx[i] == nx && qy[i] == ny) hit = 1;
    if (nx < 0 || nx >= 40 || ny < 0 || ny >= 30 || hit) m_go = 1;
    else begin
      qx.push_front(nx);
      qy.push_front(ny);
      if (!e || qx.size() > 16) begin
        void'(qx.pop_back());
        void'(qy.pop_back());
      end
      m_step = 1;
      m_ate = e;
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    if (rst) begin
      qx = {};
      qy = {};
      for (int i = 0; i < 3; i++) begin
        qx.push_back(20);
        qy.push_back(5 - i);
      end
      m_cnt = 0; m_hd = 4'b0100; m_step = 0; m_ate = 0; m_go = 0; m_valid = 1;
    end else begin
      m_step = 0;
      m_ate = 0;
      if (en && !m_go) begin
        if (m_cnt == SD - 1) begin
          m_cnt = 0;
          m_move();
        end else m_cnt++;
      end
    end
    #1;
    if (m_valid) begin
      chk("model head_x", head_x, qx[0]);
      chk("model head_y", head_y, qy[0]);
      chk("model length", length, qx.size());
      chk("model step", step, m_step);
      chk("model ate", ate, m_ate);
      chk("model game_over", game_over, m_go);
      chk("model query_hit", query_hit, m_hit(query_x, query_y));
    end
  endtask
  task automatic run(int n);
    repeat (n) cyc();
  endtask
  task automatic do_reset();
    rst = 1;
    cyc();
    rst = 0;
  endtask
  initial begin
    tbl[0]  = '{3, 1, 4'b0100, 0, 0, 0, 20, 3, 20, 5, 3, 0, 0, 0, 1};
    tbl[1]  = '{1, 1, 4'b0100, 0, 0, 0, 20, 5, 20, 6, 3, 1, 0, 0, 1};
    tbl[2]  = '{1, 1, 4'b0100, 0, 0, 0, 20, 3, 20, 6, 3, 0, 0, 0, 0};
    tbl[3]  = '{3, 1, 4'b0100, 0, 0, 0, 20, 5, 20, 7, 3, 1, 0, 0, 1};
    tbl[4]  = '{4, 1, 4'b0100, 0, 0, 0, 20, 5, 20, 8, 3, 1, 0, 0, 0};
    tbl[5]  = '{4, 1, 4'b1000, 0, 0, 0, 20, 8, 20, 9, 3, 1, 0, 0, 1};
    tbl[6]  = '{4, 1, 4'b0100, 1, 20, 10, 20, 7, 20, 10, 4, 1, 1, 0, 1};
    tbl[7]  = '{4, 1, 4'b0100, 1, 20, 10, 20, 7, 20, 11, 4, 1, 0, 0, 0};
    tbl[8]  = '{2, 0, 4'b0100, 0, 0, 0, 20, 8, 20, 11, 4, 0, 0, 0, 1};
    tbl[9]  = '{2, 1, 4'b0100, 0, 0, 0, 20, 8, 20, 11, 4, 0, 0, 0, 1};
    tbl[10] = '{3, 0, 4'b0100, 0, 0, 0, 20, 8, 20, 11, 4, 0, 0, 0, 1};
    tbl[11] = '{2, 1, 4'b0100, 0, 0, 0, 20, 9, 20, 12, 4, 1, 0, 0, 1};
    tbl[12] = '{4, 1, 4'b0001, 0, 0, 0, 20, 12, 21, 12, 4, 1, 0, 0, 1};
    tbl[13] = '{4, 1, 4'b1010, 0, 0, 0, 22, 12, 22, 12, 4, 1, 0, 0, 1};
    en = 1;
    do_reset();
    chk("reset head_x", head_x, 20);
    chk("reset head_y", head_y, 5);
    chk("reset length", length, 3);
    chk("reset game_over", game_over, 0);
    for (int k = 0; k < 14; k++) begin
      en = tbl[k].en; direction = tbl[k].dir; food_valid = tbl[k].fv;
      food_x = 6'(tbl[k].fx); food_y = 5'(tbl[k].fy);
      query_x = 6'(tbl[k].qx); query_y = 5'(tbl[k].qy);
      run(tbl[k].n);
      chk($sformatf("vec%0d head_x", k), head_x, tbl[k].hx);
      chk($sformatf("vec%0d head_y", k), head_y, tbl[k].hy);
      chk($sformatf("vec%0d length", k), length, tbl[k].len);
      chk($sformatf("vec%0d step", k), step, tbl[k].st);
      chk($sformatf("vec%0d ate", k), ate, tbl[k].at);
      chk($sformatf("vec%0d game_over", k), game_over, tbl[k].go);
      chk($sformatf("vec%0d query_hit", k), query_hit, tbl[k].qh);
    end
    food_valid = 0; en = 1;
    do_reset();
    direction = 4'b0001;
    run(4 * 19);
    chk("wall pre head_x", head_x, 39);
    run(4);
    chk("wall game_over", game_over, 1);
    chk("wall step", step, 0);
    chk("wall head_x", head_x, 39);
    en = 0; run(3); en = 1; run(8);
    chk("wall frozen game_over", game_over, 1);
    chk("wall frozen head_x", head_x, 39);
    chk("wall frozen length", length, 3);
    do_reset();
    direction = 4'b0100; food_valid = 1; food_x = 20; food_y = 6;
    run(4);
    food_y = 7;
    run(4);
    food_valid = 0;
    chk("grow length", length, 5);
    direction = 4'b0001; run(4);
    direction = 4'b1000; run(4);
    direction = 4'b0010; run(4);
    chk("self game_over", game_over, 1);
    chk("self head_x", head_x, 21);
    chk("self head_y", head_y, 6);
    chk("self step", step, 0);
    do_reset();
    direction = 4'b0100; food_valid = 1; food_x = 20; food_y = 6;
    run(4);
    food_valid = 0;
    direction = 4'b0001; run(4);
    direction = 4'b1000; run(4);
    direction = 4'b0010; run(4);
    chk("tail game_over", game_over, 0);
    chk("tail head_x", head_x, 20);
    chk("tail head_y", head_y, 5);
    chk("tail step", step, 1);
    chk("tail length", length, 4);
    do_reset();
    direction = 4'b0100;
    run(7);
    rst = 1; cyc(); rst = 0;
    chk("rst tick head_y", head_y, 5);
    chk("rst tick length", length, 3);
    chk("rst tick step", step, 0);
    direction = 4'b1010;
    run(4);
    chk("rst dir head_x", head_x, 20);
    chk("rst dir head_y", head_y, 6);
    chk("rst dir step", step, 1);
    for (int t = 0; t < 4000; t++) begin
      logic [3:0] d;
      rst = (m_go && $urandom_range(7) == 0) || $urandom_range(499) == 0;
      en = $urandom_range(9) != 0;
      d = $urandom_range(5) == 0 ? 4'($urandom) : 4'b0001 << $urandom_range(3);
      direction = d;
      food_valid = $urandom_range(2) != 0;
      if ($urandom_range(1)) begin
        food_x = 6'(qx[0] + dxf(d));
        food_y = 5'(qy[0] + dyf(d));
      end else begin
        food_x = 6'($urandom_range(39));
        food_y = 5'($urandom_range(29));
      end
      if ($urandom_range(1)) begin
        int idx = $urandom_range(qx.size() - 1);
        query_x = 6'(qx[idx]);
        query_y = 5'(qy[idx]);
      end else begin
        query_x = 6'($urandom);
        query_y = 5'($urandom);
      end
      cyc();
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
